// File: rtl/spo2_pkg.sv
// Shared definitions for the SpO2 ratio calculator.
// Holds the default parameter values, the controller state encoding, and the
// quotient width helper (dividend = 2*DW product bits plus FRAC fraction bits).
package spo2_pkg;

   localparam int DEF_DW       = 24;
   localparam int DEF_FRAC     = 8;
   localparam int DEF_COEF_A   = 110;
   localparam int DEF_COEF_B   = 25;
   localparam int DEF_SPO2_MIN = 0;
   localparam int DEF_SPO2_MAX = 100;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_MUL,
      ST_DIV,
      ST_CALC,
      ST_OUT
   } state_t;

   function automatic int qw_width(input int dw, input int frac);
      return 2 * dw + frac;
   endfunction

endpackage

// File: rtl/seq_udiv.sv
// Unsigned restoring divider, one quotient bit per clock.
// Ports:
//   clk, reset_n : clock, async active-low reset
//   go           : load num/den and start NW iteration cycles
//   num, den     : dividend (NW bits), divisor (DNW bits)
//   quo          : quotient, valid once the last step has completed
//   div_zero     : den was zero at load time (quo is then meaningless)
//   done         : high during the cycle whose edge performs the last step
module seq_udiv #(
   parameter int NW  = 56,
   parameter int DNW = 48
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           go,
   input  logic [NW-1:0]  num,
   input  logic [DNW-1:0] den,
   output logic [NW-1:0]  quo,
   output logic           div_zero,
   output logic           done
);
   localparam int CW = $clog2(NW + 1);

   logic [NW-1:0]  q_reg;
   logic [DNW-1:0] rem, den_reg;
   logic [CW-1:0]  cnt;
   logic [DNW:0]   rem_sh, diff;

   // Shift the next dividend bit into the partial remainder and trial-subtract.
   assign rem_sh = {rem, q_reg[NW-1]};
   assign diff   = rem_sh - {1'b0, den_reg};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q_reg    <= '0;
         rem      <= '0;
         den_reg  <= '0;
         cnt      <= '0;
         div_zero <= 1'b0;
      end else if (go) begin
         q_reg    <= num;
         rem      <= '0;
         den_reg  <= den;
         cnt      <= CW'(NW);
         div_zero <= (den == '0);
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
         if (rem_sh >= {1'b0, den_reg}) begin
            rem   <= diff[DNW-1:0];
            q_reg <= {q_reg[NW-2:0], 1'b1};
         end else begin
            rem   <= rem_sh[DNW-1:0];
            q_reg <= {q_reg[NW-2:0], 1'b0};
         end
      end
   end

   assign quo  = q_reg;
   assign done = (cnt == CW'(1));

endmodule

// File: rtl/spo2_ratio_calc.sv
// SpO2 ratio-of-ratios calculator.
// R = (red_ac/red_dc)/(ir_ac/ir_dc) in Q(DW-FRAC).FRAC, SpO2 = A - B*R, clamped
// and rounded to integer percent. Fixed latency: IDLE->MUL->DIV(QW)->CALC->OUT.
// Ports:
//   clk, reset_n          : clock, async active-low reset
//   start                 : input-valid strobe, honoured only when idle
//   led1_ac/dc, led2_ac/dc: IR (LED1) and red (LED2) amplitudes, unsigned DW
//   busy, done            : computation in progress / one-cycle result strobe
//   spo2, ratio_r         : result in percent and ratio R
//   sat, err_div0         : clamp/saturation applied, zero denominator
module spo2_ratio_calc
   import spo2_pkg::*;
#(
   parameter int DW       = DEF_DW,
   parameter int FRAC     = DEF_FRAC,
   parameter int COEF_A   = DEF_COEF_A,
   parameter int COEF_B   = DEF_COEF_B,
   parameter int SPO2_MIN = DEF_SPO2_MIN,
   parameter int SPO2_MAX = DEF_SPO2_MAX
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          start,
   input  logic [DW-1:0] led1_ac,
   input  logic [DW-1:0] led1_dc,
   input  logic [DW-1:0] led2_ac,
   input  logic [DW-1:0] led2_dc,
   output logic          busy,
   output logic          done,
   output logic [7:0]    spo2,
   output logic [DW-1:0] ratio_r,
   output logic          sat,
   output logic          err_div0
);
   localparam int QW = qw_width(DW, FRAC);
   localparam int PW = 2 * DW;
   localparam int SW = DW + FRAC + 8;

   state_t state, state_nx;

   logic [DW-1:0] ir_ac, ir_dc, red_ac, red_dc;
   logic [PW-1:0] prod_num, prod_den;
   logic [QW-1:0] num, quo;
   logic          div_go, div_zero, div_last;

   logic [DW-1:0]        r_val;
   logic                 r_sat, clamped;
   logic signed [SW-1:0] s_raw, s_clamp, s_round, s_lo, s_hi, s_half;
   logic [7:0]           spo2_val;

   logic [7:0]    hold_spo2;
   logic [DW-1:0] hold_r;
   logic          hold_sat, hold_err;

   // Full-width products; zero-extending the operands keeps the multiply at PW bits.
   assign prod_num = {{DW{1'b0}}, red_ac} * {{DW{1'b0}}, ir_dc};
   assign prod_den = {{DW{1'b0}}, red_dc} * {{DW{1'b0}}, ir_ac};
   assign num      = {prod_num, {FRAC{1'b0}}};
   assign div_go   = (state == ST_MUL);

   seq_udiv #(.NW(QW), .DNW(PW)) u_div (
      .clk      (clk),
      .reset_n  (reset_n),
      .go       (div_go),
      .num      (num),
      .den      (prod_den),
      .quo      (quo),
      .div_zero (div_zero),
      .done     (div_last)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: if (start) state_nx = ST_MUL;
         ST_MUL:  state_nx = ST_DIV;
         ST_DIV:  if (div_last) state_nx = ST_CALC;
         ST_CALC: state_nx = ST_OUT;
         ST_OUT:  state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   // Low in the done cycle because the FSM is already back in IDLE.
   assign busy = (state != ST_IDLE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ir_ac  <= '0;
         ir_dc  <= '0;
         red_ac <= '0;
         red_dc <= '0;
      end else if (state == ST_IDLE && start) begin
         ir_ac  <= led1_ac;
         ir_dc  <= led1_dc;
         red_ac <= led2_ac;
         red_dc <= led2_dc;
      end
   end

   // Ratio saturation, linear SpO2 map, clamp and half-up rounding.
   always_comb begin
      r_sat   = |quo[QW-1:DW];
      r_val   = (div_zero || r_sat) ? '1 : quo[DW-1:0];
      s_lo    = SW'(SPO2_MIN) << FRAC;
      s_hi    = SW'(SPO2_MAX) << FRAC;
      s_half  = SW'(1) << (FRAC - 1);
      s_raw   = (SW'(COEF_A) << FRAC) - SW'(COEF_B) * SW'(r_val);
      clamped = 1'b0;
      s_clamp = s_raw;
      if (s_raw < s_lo) begin
         s_clamp = s_lo;
         clamped = 1'b1;
      end else if (s_raw > s_hi) begin
         s_clamp = s_hi;
         clamped = 1'b1;
      end
      s_round  = s_clamp + s_half;
      spo2_val = div_zero ? 8'(SPO2_MIN) : s_round[FRAC+7:FRAC];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hold_spo2 <= '0;
         hold_r    <= '0;
         hold_sat  <= 1'b0;
         hold_err  <= 1'b0;
      end else if (state == ST_CALC) begin
         hold_spo2 <= spo2_val;
         hold_r    <= r_val;
         hold_sat  <= r_sat | clamped;
         hold_err  <= div_zero;
      end
   end

   // Results become visible together with done, and hold until the next one.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         spo2     <= '0;
         ratio_r  <= '0;
         sat      <= 1'b0;
         err_div0 <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= (state == ST_OUT);
         if (state == ST_OUT) begin
            spo2     <= hold_spo2;
            ratio_r  <= hold_r;
            sat      <= hold_sat;
            err_div0 <= hold_err;
         end
      end
   end

endmodule

// File: tb/tb_spo2_ratio_calc.sv
module tb_spo2_ratio_calc;
   localparam int DW  = 24;
   localparam int LAT = 59;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic [DW-1:0] l1a = '0, l1d = '0, l2a = '0, l2d = '0;
   logic          busy, done, sat, err_div0;
   logic [7:0]    spo2;
   logic [DW-1:0] ratio_r;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [23:0] r;
      logic [7:0]  sp;
      logic        sat;
      logic        err;
   } res_t;

   always #5 clk = ~clk;

   spo2_ratio_calc dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (start),
      .led1_ac  (l1a),
      .led1_dc  (l1d),
      .led2_ac  (l2a),
      .led2_dc  (l2d),
      .busy     (busy),
      .done     (done),
      .spo2     (spo2),
      .ratio_r  (ratio_r),
      .sat      (sat),
      .err_div0 (err_div0)
   );

   // Reference: plain integer arithmetic straight from the formulas.
   function automatic res_t model(input logic [23:0] a1, d1, a2, d2);
      res_t        o;
      logic [63:0] n, dn, q;
      longint      s;
      bit          rsat, cl;
      rsat = 0;
      cl   = 0;
      n    = (64'(a2) * 64'(d1)) << 8;
      dn   = 64'(d2) * 64'(a1);
      o.err = (dn == 0);
      if (o.err) begin
         o.r  = 24'hFFFFFF;
         rsat = 1;
      end else begin
         q = n / dn;
         if (q >= 64'h1000000) begin
            o.r  = 24'hFFFFFF;
            rsat = 1;
         end else o.r = q[23:0];
      end
      s = 110 * 256 - 25 * longint'(o.r);
      if (s < 0) begin
         s  = 0;
         cl = 1;
      end else if (s > 100 * 256) begin
         s  = 100 * 256;
         cl = 1;
      end
      o.sp  = o.err ? 8'd0 : 8'((s + 128) / 256);
      o.sat = rsat | cl;
      return o;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, expv);
      end
   endtask

   // Cycle-accurate compare process: acceptance, busy/done and held results.
   res_t last, nxt;
   int   cyc = 0, due = 0;
   bit   infl = 0;
   initial begin
      last = '{24'd0, 8'd0, 1'b0, 1'b0};
      forever begin
         @(posedge clk);
         cyc++;
         if (!reset_n) begin
            infl = 0;
            last = '{24'd0, 8'd0, 1'b0, 1'b0};
         end else if (start && (!infl || cyc > due)) begin
            infl = 1;
            due  = cyc + LAT;
            nxt  = model(l1a, l1d, l2a, l2d);
         end
         #1;
         if (reset_n) begin
            if (infl && cyc == due) last = nxt;
            chk("busy", busy, infl && cyc < due);
            chk("done", done, infl && cyc == due);
            chk("spo2", spo2, last.sp);
            chk("ratio_r", ratio_r, last.r);
            chk("sat", sat, last.sat);
            chk("err_div0", err_div0, last.err);
         end else begin
            chk("rst outputs", {busy, done, spo2, ratio_r, sat, err_div0}, 0);
         end
      end
   end

   // Waits for done from the negedge that raised start; lat counts edges after acceptance.
   task automatic wait_done(output int lat);
      bit ok;
      ok  = 0;
      lat = -1;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         @(negedge clk);
         start = 1'b0;
         if (done) begin
            lat = i;
            ok  = 1;
            break;
         end
      end
      chk("done timeout", ok, 1);
      chk("latency", lat, LAT);
   endtask

   task automatic op(input logic [23:0] a1, d1, a2, d2, input bit now);
      int lat;
      if (!now) @(negedge clk);
      l1a = a1; l1d = d1; l2a = a2; l2d = d2;
      start = 1'b1;
      wait_done(lat);
   endtask

   task automatic chk_out(input string name, input logic [23:0] r, input logic [7:0] sp,
                          input logic s, input logic e);
      chk({name, " ratio"}, ratio_r, r);
      chk({name, " spo2"}, spo2, sp);
      chk({name, " sat"}, sat, s);
      chk({name, " err"}, err_div0, e);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      res_t m;
      int   lat;
      logic [23:0] a1, d1, a2, d2;

      // Pin the reference model itself with hand-computed values.
      m = model(100, 10000, 50, 10000);
      chk("model nom", {m.r, m.sp, m.sat, m.err}, {24'd128, 8'd98, 1'b0, 1'b0});
      m = model(100, 10000, 500, 10000);
      chk("model low", {m.r, m.sp, m.sat}, {24'd1280, 8'd0, 1'b1});
      m = model(0, 10000, 50, 10000);
      chk("model div0", {m.r, m.sp, m.err}, {24'hFFFFFF, 8'd0, 1'b1});

      #1;
      chk("reset state", {busy, done, spo2, ratio_r, sat, err_div0}, 0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;

      op(100, 10000, 50, 10000, 0);
      chk_out("nominal", 128, 98, 0, 0);
      op(100, 10000, 0, 10000, 0);
      chk_out("high clamp", 0, 100, 1, 0);
      op(100, 10000, 500, 10000, 0);
      chk_out("low clamp", 1280, 0, 1, 0);
      op(0, 10000, 50, 10000, 0);
      chk_out("div0", 24'hFFFFFF, 0, 1, 1);

      // Start during busy is ignored; start in the done cycle is accepted.
      @(negedge clk);
      l1a = 100; l1d = 10000; l2a = 50; l2d = 10000;
      start = 1'b1;
      lat = -1;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         @(negedge clk);
         start = 1'b0;
         if (i == 9) begin
            l2a = 0;
            start = 1'b1;
         end
         if (done) begin
            lat = i;
            break;
         end
      end
      chk("busy-start latency", lat, LAT);
      chk_out("busy-start", 128, 98, 0, 0);
      op(100, 10000, 500, 10000, 1);
      chk_out("back2back", 1280, 0, 1, 0);

      // Reset in the middle of DIV aborts without a done pulse.
      @(negedge clk);
      l1a = 100; l1d = 10000; l2a = 50; l2d = 10000;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (20) @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("async reset", {busy, done, spo2, ratio_r, sat, err_div0}, 0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (70) @(negedge clk);
      op(100, 10000, 50, 10000, 0);
      chk_out("after reset", 128, 98, 0, 0);

      // Randomized operands, gaps and back-to-back starts.
      for (int k = 0; k < 40; k++) begin
         case ($urandom % 4)
            0: begin
               a1 = 24'($urandom); d1 = 24'($urandom);
               a2 = 24'($urandom); d2 = 24'($urandom);
            end
            1, 3: begin
               d1 = 24'($urandom_range(100000, 1000));
               d2 = 24'($urandom_range(100000, 1000));
               a1 = 24'($urandom_range(d1 / 20));
               a2 = 24'($urandom_range(d2 / 20));
               if ($urandom % 4 == 0) a1 = 0;
               if ($urandom % 4 == 0) a2 = 0;
            end
            default: begin
               a1 = 24'($urandom_range(15)); d1 = 24'($urandom_range(15));
               a2 = 24'($urandom_range(15)); d2 = 24'($urandom_range(15));
            end
         endcase
         if ($urandom % 3 == 0) op(a1, d1, a2, d2, 1);
         else begin
            repeat ($urandom % 3) @(negedge clk);
            op(a1, d1, a2, d2, 0);
         end
      end

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
